// File: rtl/MD_pkg.sv
// Shared sizing and record types for the position-ring to remote-link path.
package MD_pkg;

    localparam int NUM_REMOTE_DEST_NODES = 4;
    localparam int REMOTE_NODE_IDX_WIDTH = 3;
    localparam int POS_DATA_WIDTH        = 96;

    typedef struct packed {
        logic [REMOTE_NODE_IDX_WIDTH-1:0] dest;
        logic [POS_DATA_WIDTH-1:0]        data;
    } pos_remote_pkt_t;

    function automatic logic is_onehot(input logic [NUM_REMOTE_DEST_NODES-1:0] vec);
        return (vec != '0) && ((vec & (vec - NUM_REMOTE_DEST_NODES'(1))) == '0);
    endfunction

endpackage

// File: rtl/ring_pos_dest_fifo.sv
// Single-clock FIFO for one remote destination; count, full and empty are registered.
module ring_pos_dest_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic [WIDTH-1:0]        i_data,
    input  logic                    i_pop,
    output logic [WIDTH-1:0]        o_head,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             push_s, pop_s;

    assign push_s = i_push && !full_q;
    assign pop_s  = i_pop && !empty_q;

    // Pointer, occupancy and status next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == DEPTH_CNT);
        empty_d = (count_d == CNT_W'(0));
    end

    // Control state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents are only observed while the FIFO is non-empty
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_full  = full_q;
    assign o_empty = empty_q;
    assign o_count = count_q;

endmodule

// File: rtl/ring_pos_to_remote_buffer.sv
// Demultiplexes ring position records into per-destination FIFOs and pops the
// arbiter-granted FIFO into a registered valid/ready output stage.
module ring_pos_to_remote_buffer
    import MD_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_pos_valid,
    input  logic [POS_DATA_WIDTH-1:0]         i_pos_data,
    input  logic [REMOTE_NODE_IDX_WIDTH-1:0]  i_pos_dest,
    output logic                              o_pos_ready,
    output logic [NUM_REMOTE_DEST_NODES-1:0]  o_request,
    output logic                              o_arbiter_en,
    input  logic [NUM_REMOTE_DEST_NODES-1:0]  i_grant,
    output logic                              o_tx_valid,
    output logic [POS_DATA_WIDTH-1:0]         o_tx_data,
    output logic [REMOTE_NODE_IDX_WIDTH-1:0]  o_tx_dest,
    input  logic                              i_tx_ready,
    output logic                              o_dest_err,
    output logic                              o_grant_err,
    output logic                              o_empty
);
    localparam int N     = NUM_REMOTE_DEST_NODES;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [N-1:0]              full_s, empty_s, push_s, pop_s, req_s;
    logic [POS_DATA_WIDTH-1:0] head_s [N];
    logic [CNT_W-1:0]          count_s [N];
    logic                      dest_in_range_s, pos_ready_s, arb_en_s;
    logic                      pop_valid_s, grant_bad_s;
    pos_remote_pkt_t           grant_pkt_s, tx_pkt_q, tx_pkt_d;
    logic                      tx_valid_q, tx_valid_d;
    logic                      dest_err_q, dest_err_d, grant_err_q, grant_err_d;

    for (genvar g = 0; g < N; g++) begin : g_dest_fifo
        ring_pos_dest_fifo #(
            .WIDTH (POS_DATA_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_push  (push_s[g]),
            .i_data  (i_pos_data),
            .i_pop   (pop_s[g]),
            .o_head  (head_s[g]),
            .o_full  (full_s[g]),
            .o_empty (empty_s[g]),
            .o_count (count_s[g])
        );
        assign req_s[g] = (count_s[g] != CNT_W'(0));
    end

    assign dest_in_range_s = (32'(i_pos_dest) < N);
    assign arb_en_s        = !tx_valid_q || i_tx_ready;

    // Route the ring record to its FIFO; out-of-range records are taken and dropped
    always_comb begin
        push_s      = '0;
        pos_ready_s = 1'b1;
        for (int d = 0; d < N; d++) begin
            if (32'(i_pos_dest) == 32'(d)) begin
                pos_ready_s = !full_s[d];
                push_s[d]   = i_pos_valid && !full_s[d];
            end else begin
                push_s[d]   = 1'b0;
            end
        end
    end

    // Grant decode: only a one-hot grant to a non-empty FIFO pops
    always_comb begin
        grant_pkt_s = '0;
        pop_valid_s = 1'b0;
        grant_bad_s = 1'b0;
        for (int d = 0; d < N; d++) begin
            grant_pkt_s.data = grant_pkt_s.data | (head_s[d] & {POS_DATA_WIDTH{i_grant[d]}});
            grant_pkt_s.dest = grant_pkt_s.dest |
                               (REMOTE_NODE_IDX_WIDTH'(d) & {REMOTE_NODE_IDX_WIDTH{i_grant[d]}});
        end
        if (arb_en_s && (i_grant != '0)) begin
            if (is_onehot(i_grant) && ((i_grant & ~empty_s) != '0)) begin
                pop_valid_s = 1'b1;
            end else begin
                grant_bad_s = 1'b1;
            end
        end else begin
            pop_valid_s = 1'b0;
            grant_bad_s = 1'b0;
        end
        pop_s = pop_valid_s ? i_grant : '0;
    end

    // Output stage and sticky error next-state
    always_comb begin
        tx_pkt_d   = tx_pkt_q;
        tx_valid_d = tx_valid_q;
        if (pop_valid_s) begin
            tx_pkt_d   = grant_pkt_s;
            tx_valid_d = 1'b1;
        end else if (tx_valid_q && i_tx_ready) begin
            tx_valid_d = 1'b0;
        end else begin
            tx_valid_d = tx_valid_q;
        end
        dest_err_d  = dest_err_q | (i_pos_valid && !dest_in_range_s);
        grant_err_d = grant_err_q | grant_bad_s;
    end

    // Output stage and error flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_pkt_q    <= '0;
            tx_valid_q  <= 1'b0;
            dest_err_q  <= 1'b0;
            grant_err_q <= 1'b0;
        end else begin
            tx_pkt_q    <= tx_pkt_d;
            tx_valid_q  <= tx_valid_d;
            dest_err_q  <= dest_err_d;
            grant_err_q <= grant_err_d;
        end
    end

    assign o_pos_ready  = pos_ready_s;
    assign o_request    = req_s;
    assign o_arbiter_en = arb_en_s;
    assign o_tx_valid   = tx_valid_q;
    assign o_tx_data    = tx_pkt_q.data;
    assign o_tx_dest    = tx_pkt_q.dest;
    assign o_dest_err   = dest_err_q;
    assign o_grant_err  = grant_err_q;
    assign o_empty      = !tx_valid_q && (&empty_s);

endmodule
